// File: rtl/fx2_bridge_pkg.sv
// rtl/fx2_bridge_pkg.sv - shared opcodes, reply tags, parser states and frame width
package fx2_bridge_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_STATUS  = 8'h04;

    localparam logic [7:0] TAG_READ   = 8'hA2;
    localparam logic [7:0] TAG_STATUS = 8'hA4;

    localparam int FRAME_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_HI,
        ST_GET_LO
    } parse_state_e;

endpackage

// File: rtl/fx2_cmd_bridge_if.sv
// rtl/fx2_cmd_bridge_if.sv - command/reply/register bus bundle between FX2 bridge, register file and command bridge
interface fx2_cmd_bridge_if;

    logic [7:0]  CMD;
    logic        CMD_WR;
    logic        REQUEST_LENGTH;
    logic [15:0] LENGTH;
    logic [7:0]  FPGA_WORD;
    logic        FPGA_WORD_AVAILABLE;
    logic        FPGA_WORD_ACCEPTED;
    logic [7:0]  REG_ADDR;
    logic [15:0] REG_WDATA;
    logic        REG_WR;
    logic        REG_RD;
    logic [15:0] REG_RDATA;
    logic [7:0]  ERR_COUNT;
    logic        OVERFLOW;

    // Bridge-side view (the command bridge itself)
    modport slave (
        input  CMD, CMD_WR, REQUEST_LENGTH, FPGA_WORD_ACCEPTED, REG_RDATA,
        output LENGTH, FPGA_WORD, FPGA_WORD_AVAILABLE, REG_ADDR, REG_WDATA,
        output REG_WR, REG_RD, ERR_COUNT, OVERFLOW
    );

    // Environment view: FX2 bridge plus register file
    modport master (
        output CMD, CMD_WR, REQUEST_LENGTH, FPGA_WORD_ACCEPTED, REG_RDATA,
        input  LENGTH, FPGA_WORD, FPGA_WORD_AVAILABLE, REG_ADDR, REG_WDATA,
        input  REG_WR, REG_RD, ERR_COUNT, OVERFLOW
    );

endinterface

// File: rtl/fx2_reply_fifo.sv
// rtl/fx2_reply_fifo.sv - reply FIFO: whole 32-bit frames in, bytes out MSB first
module fx2_reply_fifo
    import fx2_bridge_pkg::*;
#(
    parameter int DEPTH_WORDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [FRAME_W-1:0] frame,
    output logic               full,
    output logic [7:0]         byte_out,
    output logic               available,
    input  logic               accepted
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
    logic [1:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] mem_q [DEPTH_WORDS];
    logic [FRAME_W-1:0] head;
    logic               do_push;

    // Extra pointer bit tells full from empty when the indices match
    assign available = (wr_q != rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push   = push && !full;
    assign head      = mem_q[rd_q[AW-1:0]];

    always_comb begin
        byte_out = 8'h00;
        if (available) begin
            case (idx_q)
                2'd0:    byte_out = head[31:24];
                2'd1:    byte_out = head[23:16];
                2'd2:    byte_out = head[15:8];
                default: byte_out = head[7:0];
            endcase
        end
    end

    always_comb begin
        wr_d  = wr_q + {{AW{1'b0}}, do_push};
        rd_d  = rd_q;
        idx_d = idx_q;
        if (accepted && available) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                rd_d = rd_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            idx_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= frame;
        end
    end

endmodule

// File: rtl/fx2_cmd_bridge.sv
// rtl/fx2_cmd_bridge.sv - command parser, register bus strobes, reply framing, LENGTH/ERR counters
// Optional STATUS opcode enabled by defining FX2_BRIDGE_STATUS_EN.
module fx2_cmd_bridge
    import fx2_bridge_pkg::*;
#(
    parameter int DEPTH_WORDS = 16
) (
    input  logic              FX2_CLK,
    input  logic              RESET,
    fx2_cmd_bridge_if.slave   bus
);

    parse_state_e       state_q, state_d, cur;
    logic               is_read_q, is_read_d;
    logic [7:0]         hi_q, hi_d;
    logic [7:0]         reg_addr_q, reg_addr_d;
    logic [15:0]        reg_wdata_q, reg_wdata_d;
    logic               reg_wr_q, reg_wr_d;
    logic               reg_rd_q, reg_rd_d;
    logic               rd_wait_q, rd_wait_d;
    logic [7:0]         err_q, err_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        cnt_q, cnt_d, cnt_inc;
    logic               ovf_q, ovf_d;
    logic [1:0]         err_inc;
    logic [8:0]         err_sum;
    logic               push, full, avail, stat_push;
    logic [FRAME_W-1:0] frame, stat_frame;
    logic [7:0]         fifo_byte;

`ifdef FX2_BRIDGE_STATUS_EN
    logic       stat_new;
    logic [1:0] stat_pend_q, stat_pend_d;
`endif

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        hi_d        = hi_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        rd_wait_d   = reg_rd_q;
        err_inc     = 2'd0;
`ifdef FX2_BRIDGE_STATUS_EN
        stat_new    = 1'b0;
`endif
        // A burst start aborts a partial command before the same-cycle byte is parsed
        cur = state_q;
        if (bus.REQUEST_LENGTH && (state_q != ST_IDLE)) begin
            cur     = ST_IDLE;
            err_inc = 2'd1;
        end
        state_d = cur;
        if (bus.CMD_WR) begin
            case (cur)
                ST_IDLE: begin
                    if (bus.CMD == OP_WRITE) begin
                        state_d   = ST_GET_ADDR;
                        is_read_d = 1'b0;
                    end else if (bus.CMD == OP_READ) begin
                        state_d   = ST_GET_ADDR;
                        is_read_d = 1'b1;
`ifdef FX2_BRIDGE_STATUS_EN
                    end else if (bus.CMD == OP_STATUS) begin
                        stat_new  = 1'b1;
`endif
                    end else begin
                        err_inc = err_inc + 2'd1;
                    end
                end
                ST_GET_ADDR: begin
                    reg_addr_d = bus.CMD;
                    if (is_read_q) begin
                        reg_rd_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_GET_HI;
                    end
                end
                ST_GET_HI: begin
                    hi_d    = bus.CMD;
                    state_d = ST_GET_LO;
                end
                default: begin
                    reg_wdata_d = {hi_q, bus.CMD};
                    reg_wr_d    = 1'b1;
                    state_d     = ST_IDLE;
                end
            endcase
        end
        err_sum = {1'b0, err_q} + {7'b0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

`ifdef FX2_BRIDGE_STATUS_EN
    // A status frame yields to a same-cycle read reply and stays pending
    always_comb begin
        stat_push   = (stat_pend_q != 2'd0) && !rd_wait_q;
        stat_pend_d = stat_pend_q + {1'b0, stat_new} - {1'b0, stat_push};
        stat_frame  = {TAG_STATUS, err_q, 6'b0, ovf_q, avail, 8'h00};
    end

    always_ff @(posedge FX2_CLK) begin
        if (RESET) stat_pend_q <= 2'd0;
        else       stat_pend_q <= stat_pend_d;
    end
`else
    assign stat_push  = 1'b0;
    assign stat_frame = '0;
`endif

    // reg_addr_q still holds the read address when REG_RDATA arrives
    assign push  = rd_wait_q || stat_push;
    assign frame = rd_wait_q ? {TAG_READ, reg_addr_q, bus.REG_RDATA} : stat_frame;

    always_comb begin
        ovf_d   = ovf_q || (push && full);
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q
                                      : cnt_q + {15'b0, (bus.FPGA_WORD_ACCEPTED && avail)};
        len_d   = len_q;
        cnt_d   = cnt_inc;
        if (bus.REQUEST_LENGTH) begin
            len_d = cnt_inc;
            cnt_d = 16'h0000;
        end
    end

    always_ff @(posedge FX2_CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            is_read_q   <= 1'b0;
            hi_q        <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 16'h0000;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            rd_wait_q   <= 1'b0;
            err_q       <= 8'h00;
            len_q       <= 16'h0000;
            cnt_q       <= 16'h0000;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            hi_q        <= hi_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            rd_wait_q   <= rd_wait_d;
            err_q       <= err_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    fx2_reply_fifo #(.DEPTH_WORDS(DEPTH_WORDS)) u_fifo (
        .clk       (FX2_CLK),
        .rst       (RESET),
        .push      (push),
        .frame     (frame),
        .full      (full),
        .byte_out  (fifo_byte),
        .available (avail),
        .accepted  (bus.FPGA_WORD_ACCEPTED)
    );

    assign bus.LENGTH              = len_q;
    assign bus.FPGA_WORD           = fifo_byte;
    assign bus.FPGA_WORD_AVAILABLE = avail;
    assign bus.REG_ADDR            = reg_addr_q;
    assign bus.REG_WDATA           = reg_wdata_q;
    assign bus.REG_WR              = reg_wr_q;
    assign bus.REG_RD              = reg_rd_q;
    assign bus.ERR_COUNT           = err_q;
    assign bus.OVERFLOW            = ovf_q;

endmodule

// File: tb/tb_fx2_cmd_bridge.sv
// tb/tb_fx2_cmd_bridge.sv - scoreboard bench for fx2_cmd_bridge (honours FX2_BRIDGE_STATUS_EN)
module tb_fx2_cmd_bridge;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fx2_cmd_bridge_if bus ();

    fx2_cmd_bridge #(.DEPTH_WORDS(DEPTH)) dut (
        .FX2_CLK (clk),
        .RESET   (rst),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int rd_pulses = 0;
    int exp_reads = 0;
    logic [7:0]  byte_q [$];
    logic [23:0] wr_q   [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rdata_of(input logic [7:0] a);
        return (a == 8'h22) ? 16'h1234 : {~a, a};
    endfunction

    // Register file model: read data valid one cycle after REG_RD
    always @(posedge clk) begin
        if (rst)             bus.REG_RDATA <= 16'h0000;
        else if (bus.REG_RD) bus.REG_RDATA <= rdata_of(bus.REG_ADDR);
    end

    // Monitor: values seen here are what the next rising edge samples
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.FPGA_WORD_AVAILABLE && bus.FPGA_WORD_ACCEPTED) begin
                if (byte_q.size() == 0) chk("unexpected_reply_byte", {24'h0, bus.FPGA_WORD}, 32'hFFFF_FFFF);
                else chk("reply_byte", {24'h0, bus.FPGA_WORD}, {24'h0, byte_q.pop_front()});
            end
            if (!bus.FPGA_WORD_AVAILABLE) chk("empty_word_zero", {24'h0, bus.FPGA_WORD}, 32'h0);
            if (bus.REG_WR) begin
                if (wr_q.size() == 0) chk("unexpected_reg_wr", {8'h0, bus.REG_ADDR, bus.REG_WDATA}, 32'hFFFF_FFFF);
                else chk("reg_wr_addr_data", {8'h0, bus.REG_ADDR, bus.REG_WDATA}, {8'h0, wr_q.pop_front()});
            end
            if (bus.REG_RD) rd_pulses++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.CMD    = b;
        bus.CMD_WR = 1'b1;
        cyc();
        bus.CMD_WR = 1'b0;
    endtask

    task automatic req_len();
        bus.REQUEST_LENGTH = 1'b1;
        cyc();
        bus.REQUEST_LENGTH = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        byte_q.push_back(b0);
        byte_q.push_back(b1);
        byte_q.push_back(b2);
        byte_q.push_back(b3);
    endtask

    task automatic expect_read(input logic [7:0] a);
        logic [15:0] d;
        d = rdata_of(a);
        push_frame(8'hA2, a, d[15:8], d[7:0]);
    endtask

    task automatic do_read(input logic [7:0] a, input bit kept);
        send(8'h02);
        send(a);
        exp_reads++;
        if (kept) expect_read(a);
    endtask

    task automatic drain();
        int k;
        k = 0;
        bus.FPGA_WORD_ACCEPTED = 1'b1;
        while ((byte_q.size() != 0 || bus.FPGA_WORD_AVAILABLE) && k < 2000) begin
            cyc();
            k++;
        end
        bus.FPGA_WORD_ACCEPTED = 1'b0;
        chk("drain_within_budget", {31'h0, (k < 2000)}, 32'h1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CMD                = 8'h00;
        bus.CMD_WR             = 1'b0;
        bus.REQUEST_LENGTH     = 1'b0;
        bus.FPGA_WORD_ACCEPTED = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        chk("rst_length",    {16'h0, bus.LENGTH}, 32'h0);
        chk("rst_reg_addr",  {24'h0, bus.REG_ADDR}, 32'h0);
        chk("rst_reg_wdata", {16'h0, bus.REG_WDATA}, 32'h0);
        chk("rst_strobes",   {30'h0, bus.REG_WR, bus.REG_RD}, 32'h0);
        chk("rst_available", {31'h0, bus.FPGA_WORD_AVAILABLE}, 32'h0);
        chk("rst_overflow",  {31'h0, bus.OVERFLOW}, 32'h0);
        chk("rst_err_count", {24'h0, bus.ERR_COUNT}, 32'h0);
        chk("rst_word",      {24'h0, bus.FPGA_WORD}, 32'h0);

        // WRITE 0x10 <- 0xBEEF
        wr_q.push_back({8'h10, 16'hBEEF});
        send(8'h01); send(8'h10); send(8'hBE); send(8'hEF);
        chk("wr_strobe_t_plus_1", {31'h0, bus.REG_WR}, 32'h1);
        cyc();
        chk("wr_single_pulse", {31'h0, bus.REG_WR}, 32'h0);
        chk("wr_err_count", {24'h0, bus.ERR_COUNT}, 32'h0);

        // READ 0x22 -> A2 22 12 34, latency check
        send(8'h02); send(8'h22);
        exp_reads++;
        chk("rd_strobe_t_plus_1", {31'h0, bus.REG_RD}, 32'h1);
        cyc();
        chk("rd_single_pulse", {31'h0, bus.REG_RD}, 32'h0);
        chk("rd_not_yet_available", {31'h0, bus.FPGA_WORD_AVAILABLE}, 32'h0);
        cyc();
        chk("rd_available_t_plus_3", {31'h0, bus.FPGA_WORD_AVAILABLE}, 32'h1);
        push_frame(8'hA2, 8'h22, 8'h12, 8'h34);
        drain();
        req_len();
        chk("length_after_read", {16'h0, bus.LENGTH}, 32'd4);

        // Protocol errors
        send(8'h01);
        req_len();
        chk("abort_err_count", {24'h0, bus.ERR_COUNT}, 32'd1);
        send(8'h7F);
        chk("bad_opcode_err_count", {24'h0, bus.ERR_COUNT}, 32'd2);
        send(8'h02);
        bus.REQUEST_LENGTH = 1'b1;
        send(8'h02);
        bus.REQUEST_LENGTH = 1'b0;
        chk("abort_with_byte_err_count", {24'h0, bus.ERR_COUNT}, 32'd3);
        send(8'h33);
        exp_reads++;
        chk("reparsed_read_strobe", {31'h0, bus.REG_RD}, 32'h1);
        expect_read(8'h33);
        drain();

        // STATUS opcode with a frame already waiting
        do_read(8'h44, 1'b1);
        repeat (3) cyc();
        chk("status_pre_available", {31'h0, bus.FPGA_WORD_AVAILABLE}, 32'h1);
        send(8'h04);
        cyc();
`ifdef FX2_BRIDGE_STATUS_EN
        push_frame(8'hA4, 8'h03, 8'h01, 8'h00);
        chk("status_err_count", {24'h0, bus.ERR_COUNT}, 32'd3);
`else
        chk("status_unknown_err_count", {24'h0, bus.ERR_COUNT}, 32'd4);
`endif
        drain();

        // Overflow: DEPTH+1 back-to-back reads, nothing accepted
        chk("ovf_before", {31'h0, bus.OVERFLOW}, 32'h0);
        for (int i = 0; i <= DEPTH; i++) begin
            logic [7:0] a;
            a = 8'h50 + i[7:0];
            do_read(a, i < DEPTH);
        end
        repeat (4) cyc();
        chk("ovf_sticky_set", {31'h0, bus.OVERFLOW}, 32'h1);
        drain();
        chk("ovf_still_set", {31'h0, bus.OVERFLOW}, 32'h1);

        // LENGTH: accept coinciding with REQUEST_LENGTH is counted
        req_len();
        do_read(8'h66, 1'b1);
        repeat (3) cyc();
        bus.FPGA_WORD_ACCEPTED = 1'b1;
        repeat (3) cyc();
        bus.REQUEST_LENGTH = 1'b1;
        cyc();
        bus.REQUEST_LENGTH = 1'b0;
        bus.FPGA_WORD_ACCEPTED = 1'b0;
        chk("length_same_cycle_accept", {16'h0, bus.LENGTH}, 32'd4);
        req_len();
        chk("length_restart_zero", {16'h0, bus.LENGTH}, 32'd0);
        chk("edge_frame_drained", byte_q.size(), 32'd0);

        // LENGTH saturation: 16385 reads x 4 bytes, one read per 4 cycles
        bus.FPGA_WORD_ACCEPTED = 1'b1;
        for (int i = 0; i < 16385; i++) begin
            do_read(i[7:0], 1'b1);
            cyc();
            cyc();
        end
        drain();
        req_len();
        chk("length_saturated", {16'h0, bus.LENGTH}, 32'h0000FFFF);
        req_len();
        chk("length_cleared", {16'h0, bus.LENGTH}, 32'h0);

        repeat (4) cyc();
        chk("reg_rd_pulse_count", rd_pulses, exp_reads);
        chk("pending_writes", wr_q.size(), 32'd0);
        chk("pending_reply_bytes", byte_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
